// File: rtl/adder_case2_driver.sv
// Host-side initiator for the 128-bit adder: packs host words into {b,a}, issues, captures the sum, streams it back.
// Optional result timeout is compiled in with `define ADDER_DRV_TIMEOUT_EN.
module adder_case2_driver #(
   parameter int IN_W    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] s_tdata,
   input  logic            s_tvalid,
   output logic            s_tready,
   output logic [127:0]    add_din,
   output logic            add_din_tvalid,
   input  logic [63:0]     add_dout,
   input  logic            add_dout_tvalid,
   output logic [IN_W-1:0] m_tdata,
   output logic            m_tvalid,
   input  logic            m_tready,
   output logic            busy,
   output logic            timeout_err
);
   localparam int NIN  = 128 / IN_W;
   localparam int NOUT = 64 / IN_W;
   localparam int KW   = $clog2(NIN);
   localparam int JW   = (NOUT > 1) ? $clog2(NOUT) : 1;

   if (!(IN_W == 16 || IN_W == 32 || IN_W == 64) || TIMEOUT < 1) begin : g_bad_param
      $error("adder_case2_driver: unsupported IN_W or TIMEOUT");
   end

   typedef enum logic [1:0] {ST_COLLECT, ST_ISSUE, ST_WAIT, ST_SEND} state_t;

   state_t                       state_q, state_d;
   logic [KW-1:0]                k_q, k_d;
   logic [JW-1:0]                j_q, j_d;
   logic [NIN-1:0][IN_W-1:0]     din_q;
   logic [NOUT-1:0][IN_W-1:0]    res_q, res_d;
   logic                         din_we, res_we;
   logic                         rdy_q, rdy_d;

`ifdef ADDER_DRV_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      j_d     = j_q;
      din_we  = 1'b0;
      res_we  = 1'b0;
      res_d   = add_dout;
`ifdef ADDER_DRV_TIMEOUT_EN
      cnt_d   = '0;
      tmo_d   = tmo_q;
`endif
      case (state_q)
         ST_COLLECT: begin
            if (s_tvalid && rdy_q) begin
               din_we = 1'b1;
               if (k_q == KW'(NIN - 1)) begin
                  k_d     = '0;
                  state_d = ST_ISSUE;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (add_dout_tvalid) begin
               res_we  = 1'b1;
               state_d = ST_SEND;
            end
`ifdef ADDER_DRV_TIMEOUT_EN
            // After TIMEOUT silent WAIT cycles, hand the host an all-ones result.
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_we  = 1'b1;
               res_d   = '1;
               tmo_d   = 1'b1;
               state_d = ST_SEND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_SEND: begin
            if (m_tready) begin
               if (j_q == JW'(NOUT - 1)) begin
                  j_d     = '0;
                  state_d = ST_COLLECT;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         default: state_d = ST_COLLECT;
      endcase
      // Registered ready keeps s_tready low while reset is asserted.
      rdy_d = (state_d == ST_COLLECT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
         k_q     <= '0;
         j_q     <= '0;
         din_q   <= '0;
         res_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         j_q     <= j_d;
         rdy_q   <= rdy_d;
         if (din_we) din_q[k_q] <= s_tdata;
         if (res_we) res_q <= res_d;
      end
   end

`ifdef ADDER_DRV_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign s_tready       = rdy_q;
   assign add_din        = din_q;
   assign add_din_tvalid = (state_q == ST_ISSUE);
   assign m_tvalid       = (state_q == ST_SEND);
   assign m_tdata        = res_q[j_q];
   assign busy           = (state_q != ST_COLLECT);

endmodule

// File: tb/tb_adder_case2_driver.sv
// Directed bench for adder_case2_driver with a 1-cycle model adder and a result scoreboard.
module tb_adder_case2_driver;
   localparam int IN_W = 32;
   localparam int NIN  = 128 / IN_W;
   localparam int NOUT = 64 / IN_W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [IN_W-1:0] s_tdata;
   logic            s_tvalid;
   logic            s_tready;
   logic [127:0]    add_din;
   logic            add_din_tvalid;
   logic [63:0]     add_dout = '0;
   logic            add_dout_tvalid = 1'b0;
   logic [IN_W-1:0] m_tdata;
   logic            m_tvalid;
   logic            m_tready;
   logic            busy;
   logic            timeout_err;
   logic            adder_en;

   int total = 0;
   int bad   = 0;
   logic [IN_W-1:0] exp_q[$];

   adder_case2_driver #(.IN_W(IN_W), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .add_din(add_din), .add_din_tvalid(add_din_tvalid),
      .add_dout(add_dout), .add_dout_tvalid(add_dout_tvalid),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // model adder: one-cycle latency, can be silenced for the timeout case
   always @(posedge clk) begin
      add_dout_tvalid <= add_din_tvalid && adder_en;
      add_dout        <= add_din[63:0] + add_din[127:64];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard consumer
   always @(negedge clk) begin
      if (rst_n && m_tvalid && m_tready) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL sb_unexpected observed=%0h expected=none", m_tdata);
         end
         if (exp_q.size() != 0) chk("rx_word", m_tdata, exp_q.pop_front());
      end
   end

   task automatic push_sum(input logic [63:0] s);
      for (int i = 0; i < NOUT; i++) exp_q.push_back(s[i*IN_W +: IN_W]);
   endtask

   task automatic send_word(input logic [IN_W-1:0] w);
      int n = 0;
      s_tdata  = w;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("s_handshake_bound", n, 0);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic send_txn(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] v;
      v = {b, a};
      for (int i = 0; i < NIN; i++) send_word(v[i*IN_W +: IN_W]);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
      chk({tag, "_idle_bound"}, (n < 200), 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic wait_mvalid(input string tag);
      int n = 0;
      while (!m_tvalid && n < 200) begin @(posedge clk); #1; n++; end
      chk({tag, "_mvalid_bound"}, (n < 200), 1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b, sum;
      rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1; adder_en = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_add_din", add_din, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_s_tready", s_tready, 1);

      // basic add with latency checks
      push_sum(64'h3);
      send_word(32'h1); send_word(32'h0); send_word(32'h2); send_word(32'h0);
      chk("basic_issue", add_din_tvalid, 1);
      chk("basic_din", add_din, {64'h2, 64'h1});
      chk("basic_s_tready_issue", s_tready, 0);
      @(posedge clk); #1;
      chk("basic_issue_once", add_din_tvalid, 0);
      @(posedge clk); #1;
      chk("basic_lat_mvalid", m_tvalid, 1);
      wait_idle("basic");
      chk("basic_busy_low", busy, 0);

      // wrap-around
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1;
      push_sum(a + b);
      send_txn(a, b);
      wait_idle("wrap");
      chk("wrap_timeout_err", timeout_err, 0);

      // backpressure: result held, input blocked
      a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_2222_3333_4444;
      sum = a + b;
      m_tready = 1'b0;
      push_sum(sum);
      send_txn(a, b);
      wait_mvalid("bp");
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         chk("bp_mvalid", m_tvalid, 1);
         chk("bp_mtdata", m_tdata, sum[31:0]);
         chk("bp_s_tready", s_tready, 0);
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      wait_idle("bp");

      // reset mid-SEND
      m_tready = 1'b0;
      push_sum(64'h55 + 64'h66);
      send_txn(64'h55, 64'h66);
      wait_mvalid("rstsend");
      rst_n = 1'b0; #1;
      chk("rstsend_s_tready", s_tready, 0);
      chk("rstsend_m_tvalid", m_tvalid, 0);
      chk("rstsend_issue", add_din_tvalid, 0);
      chk("rstsend_busy", busy, 0);
      chk("rstsend_timeout_err", timeout_err, 0);
      exp_q.delete();
      m_tready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rstsend_rel_s_tready", s_tready, 1);

      // gapped partial collect, then reset discards it
      send_word(32'h9);
      repeat (3) @(posedge clk); #1;
      send_word(32'h8);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b0; #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_sum(64'hC);
      send_word(32'h5);
      @(posedge clk); #1;
      send_word(32'h0);
      send_word(32'h7);
      repeat (2) @(posedge clk); #1;
      send_word(32'h0);
      chk("gap_issue", add_din_tvalid, 1);
      chk("gap_din", add_din, {64'h7, 64'h5});
      wait_idle("gap");

`ifdef ADDER_DRV_TIMEOUT_EN
      // silent adder: all-ones result after 16 WAIT cycles
      adder_en = 1'b0;
      m_tready = 1'b0;
      push_sum(64'hFFFF_FFFF_FFFF_FFFF);
      send_txn(64'h10, 64'h20);
      repeat (16) @(posedge clk); #1;
      chk("tmo_still_wait", m_tvalid, 0);
      chk("tmo_err_early", timeout_err, 0);
      @(posedge clk); #1;
      chk("tmo_send", m_tvalid, 1);
      chk("tmo_err_set", timeout_err, 1);
      m_tready = 1'b1;
      wait_idle("tmo");
      adder_en = 1'b1;
      push_sum(64'h30 + 64'h40);
      send_txn(64'h30, 64'h40);
      wait_idle("tmo_after");
      chk("tmo_err_sticky", timeout_err, 1);
`else
      chk("no_tmo_err", timeout_err, 0);
`endif

      chk("sb_leftover", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
